sram_like_bridge: RTL
=====================

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus/CPU address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 or 64; STRB = DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_en  in  1  CPU access request, held until cpu_stall low.
REQ-006 SHALL have port cpu_wen  in  STRB  byte write enables; all-zero means read.
REQ-007 SHALL have port cpu_addr  in  ADDR_WIDTH  byte address.
REQ-008 SHALL have port cpu_wdata  in  DATA_WIDTH  write data.
REQ-009 SHALL have port cpu_rdata  out  DATA_WIDTH  registered read data.
REQ-010 SHALL have port cpu_stall  out  1  CPU must hold request and freeze while high.
REQ-011 SHALL have port bus_req  out  1  request valid.
REQ-012 SHALL have port bus_wr  out  1  1 = write.
REQ-013 SHALL have port bus_size  out  2  log2(bytes): 0 byte, 1 half, 2 word, 3 dword.
REQ-014 SHALL have port bus_addr  out  ADDR_WIDTH  request address.
REQ-015 SHALL have port bus_wdata  out  DATA_WIDTH  write data.
REQ-016 SHALL have port bus_addr_ok  in  1  request accepted this cycle.
REQ-017 SHALL have port bus_data_ok  in  1  response/write-ack this cycle.
REQ-018 SHALL have port bus_rdata  in  DATA_WIDTH  read data, valid with bus_data_ok.

Function
REQ-019 SHALL implement FSM IDLE, REQ, WAIT, RESP; one transaction outstanding maximum.
REQ-020 IDLE: cpu_en=1 -> REQ; bus_addr/bus_wr/bus_size/bus_wdata registered on this edge.
REQ-021 REQ: bus_req=1; addr_ok=1 & data_ok=0 -> WAIT; addr_ok=1 & data_ok=1 -> RESP with rdata capture; addr_ok=0 -> stay, fields stable.
REQ-022 WAIT: bus_req=0; data_ok=1 -> RESP, cpu_rdata <= bus_rdata (reads only; writes leave cpu_rdata unchanged).
REQ-023 RESP: unconditional -> IDLE.
REQ-024 cpu_stall SHALL be combinational: 1 when cpu_en=1 and state != RESP, else 0.
REQ-025 Minimum latency: request in IDLE at cycle N, zero-wait bus -> RESP at N+2, cpu_stall low at N+2 only.
REQ-026 bus_wr = |cpu_wen; reads use bus_size = log2(STRB) and address unmodified.
REQ-027 Writes: bus_size = log2(popcount(cpu_wen)); bus_addr low log2(STRB) bits = index of lowest set bit of cpu_wen.
REQ-028 Non-contiguous or non-power-of-two cpu_wen SHALL be issued as full-width write (size log2(STRB)), address low bits cleared.
REQ-029 bus_data_ok in IDLE or RESP SHALL be ignored; bus_addr_ok outside REQ SHALL be ignored.
REQ-030 cpu_en dropping while in REQ/WAIT SHALL not abort; transaction completes, RESP then IDLE.

Reset
REQ-031 On rst: state IDLE, bus_req 0, bus_wr 0, bus_size 0, bus_addr 0, bus_wdata 0, cpu_rdata 0; cpu_stall then follows REQ-024.
REQ-032 rst mid-transaction SHALL drop it immediately; late data_ok after release ignored per REQ-029.

Configuration
REQ-033 Macro SRAM_BRIDGE_ADDR_XLATE_EN defined and ADDR_WIDTH=32: addresses 0x8000_0000-0xBFFF_FFFF (kseg0/kseg1) SHALL have bits [31:29] cleared on bus_addr; others pass through.
REQ-034 Macro undefined: bus_addr = computed cpu_addr untranslated, no translation logic present.

Verification
REQ-035 Read 0x0000_1000, addr_ok+data_ok same cycle in REQ, rdata 0xDEADBEEF -> cpu_stall high 2 cycles, cpu_rdata=0xDEADBEEF at RESP, bus_size=2.
REQ-036 Write wen=4'b1100 addr 0x0000_2000 -> bus_wr=1, bus_size=1, bus_addr=0x0000_2002; addr_ok delayed 3 cycles -> bus fields stable throughout.
REQ-037 Read, data_ok 5 cycles after addr_ok -> WAIT held 5 cycles, bus_req low in WAIT, cpu_stall low exactly 1 cycle.
REQ-038 With SRAM_BRIDGE_ADDR_XLATE_EN, read 0xBFC0_0000 -> bus_addr=0x1FC0_0000; without macro -> 0xBFC0_0000.
REQ-039 rst asserted in WAIT, stray data_ok next cycle -> state IDLE, bus_req 0, cpu_rdata 0 unchanged.
REQ-040 DATA_WIDTH=64, wen=8'hF0 addr 0x100 -> bus_size=2, bus_addr=0x104.

Source files
------------

// File: rtl/sram_like_bridge.sv
// CPU sram-style request to SRAM-like bus (addr_ok/data_ok) bridge, one access in flight.
// Optional kseg0/kseg1 address stripping when SRAM_BRIDGE_ADDR_XLATE_EN is defined.
module sram_like_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_en,
    input  logic [DATA_WIDTH/8-1:0] cpu_wen,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    output logic                    bus_req,
    output logic                    bus_wr,
    output logic [1:0]              bus_size,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_addr_ok,
    input  logic                    bus_data_ok,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(STRB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    bus_wr_q, bus_wr_d;
    logic [1:0]              bus_size_q, bus_size_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic                    wr;
    logic [LSB:0]            cnt;
    logic [LSB-1:0]          low;
    logic [1:0]              sz;
    logic [STRB-1:0]         shifted;
    logic                    contig;
    logic                    pow2;
    logic [1:0]              enc_size;
    logic [ADDR_WIDTH-1:0]   enc_addr;
    logic [ADDR_WIDTH-1:0]   xl_addr;

    // Byte-enable mask -> (size, low address bits); odd masks fall back to full width.
    always_comb begin
        wr  = |cpu_wen;
        cnt = '0;
        low = '0;
        sz  = '0;
        for (int i = 0; i < STRB; i++) begin
            if (cpu_wen[i]) begin
                cnt = cnt + (LSB+1)'(1);
            end
        end
        for (int i = STRB - 1; i >= 0; i--) begin
            if (cpu_wen[i]) begin
                low = LSB'(i);
            end
        end
        for (int i = 0; i <= LSB; i++) begin
            if (cnt[i]) begin
                sz = 2'(i);
            end
        end
        shifted  = cpu_wen >> low;
        contig   = ((shifted & (shifted + STRB'(1))) == '0);
        pow2     = ((cnt & (cnt - (LSB+1)'(1))) == '0);
        enc_size = 2'(LSB);
        enc_addr = cpu_addr;
        if (wr) begin
            if (contig && pow2) begin
                enc_size = sz;
                enc_addr = {cpu_addr[ADDR_WIDTH-1:LSB], low};
            end else begin
                enc_addr = {cpu_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
            end
        end
    end

`ifdef SRAM_BRIDGE_ADDR_XLATE_EN
    generate
        if (ADDR_WIDTH == 32) begin : g_xlate
            always_comb begin
                xl_addr = enc_addr;
                if (enc_addr[31:30] == 2'b10) begin
                    xl_addr[31:29] = 3'b000;
                end
            end
        end else begin : g_pass
            assign xl_addr = enc_addr;
        end
    endgenerate
`else
    assign xl_addr = enc_addr;
`endif

    always_comb begin
        state_d     = state_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_en) begin
                    state_d     = S_REQ;
                    bus_wr_d    = wr;
                    bus_size_d  = enc_size;
                    bus_addr_d  = xl_addr;
                    bus_wdata_d = cpu_wdata;
                end
            end
            S_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        state_d = S_RESP;
                        if (!bus_wr_q) begin
                            cpu_rdata_d = bus_rdata;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    state_d = S_RESP;
                    if (!bus_wr_q) begin
                        cpu_rdata_d = bus_rdata;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus_req   = (state_q == S_REQ);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_stall = cpu_en && (state_q != S_RESP);
endmodule
